// File: rtl/arith_pkg.sv
// arith_pkg: op encodings, sequencer states and program-word geometry
package arith_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESULT, DONE} state_e;
    localparam int OP_W = 2;
    function automatic int word_w(input int w);
        return OP_W + 2 * w;
    endfunction
endpackage

// File: rtl/prog_mem.sv
// prog_mem: program store with one write port and an asynchronous read port
module prog_mem
    import arith_pkg::*;
#(
    parameter int W = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int WW = word_w(W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);
    logic [WW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: steps a stored program of {op, a, b} entries through an external arithmetic unit
module operand_sequencer
    import arith_pkg::*;
#(
    parameter int W = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int WW = word_w(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_en,
    input  logic [AW-1:0]  load_addr,
    input  logic [WW-1:0]  load_data,
    input  logic [AW:0]    count,
    input  logic           start,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [1:0]     op_sel,
    output logic           op_valid,
    input  logic           op_ready,
    input  logic [2*W-1:0] res_in,
    input  logic           res_in_valid,
    output logic           res_valid,
    output logic [2*W-1:0] res_data,
    output logic [AW-1:0]  res_idx,
    output logic           busy,
    output logic           seq_done,
    output logic           err_dz
);
    state_e        state;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_clamped;
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] word;
    logic          word_dz;
    logic          last;
    // the read port always looks at the entry about to be issued next
    assign rd_addr     = (state == IDLE) ? '0 : idx + 1'b1;
    assign word_dz     = word[WW-1 -: OP_W] == OP_DIV && word[W-1:0] == '0;
    assign last        = {1'b0, idx} == cnt - 1'b1;
    assign cnt_clamped = count > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : count;
    prog_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (load_en && !busy),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (word)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
            err_dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && count != '0) begin
                    cnt                  <= cnt_clamped;
                    idx                  <= '0;
                    err_dz               <= 1'b0;
                    busy                 <= 1'b1;
                    {op_sel, op_a, op_b} <= word;
                    op_valid             <= !word_dz;
                    state                <= ISSUE;
                end
                ISSUE: if (op_sel == OP_DIV && op_b == '0) begin
                    res_data  <= '1;
                    res_idx   <= idx;
                    err_dz    <= 1'b1;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end else if (op_ready) begin
                    op_valid <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (res_in_valid) begin
                    res_data  <= res_in;
                    res_idx   <= idx;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    res_valid <= 1'b0;
                    if (last) begin
                        seq_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx                  <= idx + 1'b1;
                        {op_sel, op_a, op_b} <= word;
                        op_valid             <= !word_dz;
                        state                <= ISSUE;
                    end
                end
                DONE: begin
                    seq_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: scoreboard bench with a behavioural arithmetic unit responder
module tb_operand_sequencer;
    import arith_pkg::*;
    localparam int W = 4;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    localparam int WW = 10;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_en = 1'b0;
    logic [AW-1:0]  load_addr = '0;
    logic [WW-1:0]  load_data = '0;
    logic [AW:0]    count = '0;
    logic           start = 1'b0;
    logic [W-1:0]   op_a, op_b;
    logic [1:0]     op_sel;
    logic           op_valid;
    logic           op_ready = 1'b1;
    logic [2*W-1:0] res_in = '0;
    logic           res_in_valid;
    logic           res_valid;
    logic [2*W-1:0] res_data;
    logic [AW-1:0]  res_idx;
    logic           busy, seq_done, err_dz;
    int n_tests = 0;
    int n_fail = 0;
    int n_res = 0;
    bit valid_seen = 0;
    logic [AW+2*W-1:0] sb [$];
    logic [AW+2*W-1:0] exp_r;
    logic [WW-1:0] prog [DEPTH];
    operand_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .count(count), .start(start), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .op_valid(op_valid), .op_ready(op_ready), .res_in(res_in), .res_in_valid(res_in_valid),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx), .busy(busy),
        .seq_done(seq_done), .err_dz(err_dz)
    );
    always #5 clk = ~clk;
    assign res_in_valid = 1'b1;
    function automatic logic [2*W-1:0] calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op == 2'd0) return {{(W-1){1'b0}}, {1'b0, a} + {1'b0, b}};
        if (op == 2'd1) return {{(W-1){1'b0}}, {1'b0, a} - {1'b0, b}};
        if (op == 2'd2) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (b == '0) return '1;
        return {a % b, a / b};
    endfunction
    always @(posedge clk)
        if (op_valid && op_ready) res_in <= calc(op_sel, op_a, op_b);
    always @(negedge clk) begin
        if (op_valid) valid_seen = 1;
        if (res_valid) begin
            n_res++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got idx=%0d data=%h, none expected", res_idx, res_data);
            end else begin
                exp_r = sb.pop_front();
                if ({res_idx, res_data} !== exp_r) begin
                    n_fail++;
                    $display("FAIL result: got idx=%0d data=%h, expected idx=%0d data=%h",
                             res_idx, res_data, exp_r[2*W+AW-1:2*W], exp_r[2*W-1:0]);
                end
            end
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic load(input int addr, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        load_en = 1'b1;
        load_addr = AW'(addr);
        load_data = {op, a, b};
        prog[addr] = {op, a, b};
        tick();
        load_en = 1'b0;
    endtask
    task automatic push_seq(input int n);
        for (int i = 0; i < n && i < DEPTH; i++)
            sb.push_back({AW'(i), calc(prog[i][9:8], prog[i][7:4], prog[i][3:0])});
    endtask
    task automatic go(input int n);
        count = (AW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_done(input string name);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (seq_done) begin
                ok = 1;
                break;
            end
            tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done: seq_done not seen within 300 cycles", name);
        end
    endtask
    task automatic check_outputs_zero(input string name);
        n_tests++;
        if ({op_valid, op_a, op_b, op_sel, res_valid, res_data, res_idx, busy, seq_done, err_dz} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs op_valid=%b a=%h b=%h sel=%b rv=%b rd=%h ri=%0d busy=%b done=%b dz=%b, expected all 0",
                     name, op_valid, op_a, op_b, op_sel, res_valid, res_data, res_idx, busy, seq_done, err_dz);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
    endtask
    task automatic test_add();
        load(0, OP_ADD, 4'd3, 4'd5);
        push_seq(1);
        go(1);
        n_tests++;
        if (!(op_valid === 1'b1 && busy === 1'b1 && {op_a, op_b, op_sel} === {4'd3, 4'd5, 2'b00})) begin
            n_fail++;
            $display("FAIL add_issue: got valid=%b busy=%b a=%h b=%h sel=%b, expected 1 1 3 5 00", op_valid, busy, op_a, op_b, op_sel);
        end
        tick();
        n_tests++;
        if (op_valid !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_wait: got valid=%b res_valid=%b, expected 0 0", op_valid, res_valid);
        end
        tick();
        n_tests++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_latency: res_valid=%b in third cycle, expected 1", res_valid);
        end
        tick();
        n_tests++;
        if (seq_done !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: got seq_done=%b res_valid=%b, expected 1 0", seq_done, res_valid);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || seq_done !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL add_idle: got busy=%b seq_done=%b pending=%0d, expected 0 0 0", busy, seq_done, sb.size());
        end
    endtask
    task automatic test_stall();
        int n0;
        load(0, OP_MUL, 4'd15, 4'd15);
        load(1, OP_DIV, 4'd9, 4'd2);
        op_ready = 1'b0;
        push_seq(2);
        n0 = n_res;
        go(2);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (!(op_valid === 1'b1 && {op_a, op_b, op_sel} === {4'd15, 4'd15, 2'b10})) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b a=%h b=%h sel=%b, expected 1 f f 10", i, op_valid, op_a, op_b, op_sel);
            end
            tick();
        end
        op_ready = 1'b1;
        wait_done("stall");
        tick();
        n_tests++;
        if (n_res - n0 != 2 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, %0d pending, expected 2 and 0", n_res - n0, sb.size());
        end
    endtask
    task automatic test_div_zero();
        load(0, OP_DIV, 4'd7, 4'd0);
        push_seq(1);
        valid_seen = 0;
        go(1);
        wait_done("dz");
        n_tests++;
        if (err_dz !== 1'b1 || valid_seen) begin
            n_fail++;
            $display("FAIL dz_flag: got err_dz=%b op_valid_seen=%b, expected 1 0", err_dz, valid_seen);
        end
        tick(2);
        n_tests++;
        if (err_dz !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_sticky: got err_dz=%b busy=%b in idle, expected 1 0", err_dz, busy);
        end
    endtask
    task automatic test_reset_mid();
        load(0, OP_SUB, 4'd2, 4'd5);
        push_seq(1);
        go(1);
        n_tests++;
        if (err_dz !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_clear: got err_dz=%b after start, expected 0", err_dz);
        end
        tick();
        n_tests++;
        if (op_valid !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait: got valid=%b busy=%b rv=%b, expected 0 1 0", op_valid, busy, res_valid);
        end
        rst = 1'b1;
        tick();
        check_outputs_zero("mid_reset");
        sb.delete();
        rst = 1'b0;
        tick();
        push_seq(1);
        go(1);
        wait_done("rerun");
        tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rerun_pending: got %0d pending results, expected 0", sb.size());
        end
    endtask
    task automatic test_ignore();
        int n0;
        for (int i = 0; i < DEPTH; i++)
            load(i, 2'(i % 4), W'(i + 3), W'((i * 5) % 16));
        count = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(3);
        n_tests++;
        if (busy !== 1'b0 || op_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL count_zero: got busy=%b op_valid=%b, expected 0 0", busy, op_valid);
        end
        push_seq(12);
        n0 = n_res;
        go(12);
        tick(2);
        count = 4'd3;
        start = 1'b1;
        load_en = 1'b1;
        load_addr = 3'd3;
        load_data = {OP_ADD, 4'hf, 4'hf};
        tick();
        start = 1'b0;
        load_en = 1'b0;
        wait_done("clamp");
        tick(10);
        n_tests++;
        if (n_res - n0 != 8 || sb.size() != 0 || busy !== 1'b0 || err_dz !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d results pending=%0d busy=%b dz=%b, expected 8 0 0 0",
                     n_res - n0, sb.size(), busy, err_dz);
        end
        push_seq(4);
        n0 = n_res;
        go(4);
        wait_done("prog_kept");
        tick();
        n_tests++;
        if (n_res - n0 != 4 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL prog_kept: got %0d results, %0d pending, expected 4 and 0", n_res - n0, sb.size());
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        tick();
        test_reset();
        test_add();
        test_stall();
        test_div_zero();
        test_reset_mid();
        test_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter W, default 4, operand width.
REQ-002 SHALL have parameter DEPTH, default 8, program entries (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port load_en, input, 1, program-write strobe.
REQ-006 SHALL have port load_addr, input, log2(DEPTH), program-write address.
REQ-007 SHALL have port load_data, input, 2+2W, program word {op[1:0], a[W-1:0], b[W-1:0]}.
REQ-008 SHALL have port count, input, log2(DEPTH)+1, number of entries to run.
REQ-009 SHALL have port start, input, 1, begin-sequence request.
REQ-010 SHALL have ports op_a and op_b, output, W each, operands to the arithmetic unit.
REQ-011 SHALL have port op_sel, output, 2, operation to the arithmetic unit: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-012 SHALL have port op_valid, output, 1, operation-offered signal.
REQ-013 SHALL have port op_ready, input, 1, arithmetic-unit accept signal.
REQ-014 SHALL have port res_in, input, 2W, arithmetic result: {carry, sum}, product, or {remainder, quotient}.
REQ-015 SHALL have port res_in_valid, input, 1, result-present signal.
REQ-016 SHALL have port res_valid, output, 1, one-cycle result pulse.
REQ-017 SHALL have port res_data, output, 2W, captured result.
REQ-018 SHALL have port res_idx, output, log2(DEPTH), program index of res_data.
REQ-019 SHALL have ports busy, seq_done and err_dz, output, 1 each.

Function
REQ-020 SHALL hold DEPTH program words; when load_en=1 and busy=0, SHALL write load_data to load_addr; writes while busy=1 SHALL be ignored.
REQ-021 SHALL implement states IDLE, ISSUE, WAIT, RESULT, DONE.
REQ-022 In IDLE, start=1 with count!=0 SHALL latch count (clamped to DEPTH), clear idx and err_dz, and enter ISSUE next cycle; start with count=0 SHALL be ignored.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 In ISSUE, op_valid SHALL be 1 with op_a, op_b and op_sel from entry idx, held stable until op_ready=1.
REQ-026 The transfer cycle (op_valid & op_ready) SHALL move ISSUE to WAIT; op_valid SHALL be 0 outside ISSUE.
REQ-027 In WAIT, res_in_valid=1 SHALL capture res_in into res_data and idx into res_idx, then enter RESULT; res_in_valid in any other state SHALL be ignored.
REQ-028 In RESULT, res_valid SHALL be 1 for exactly one cycle; if idx=latched_count-1, next state SHALL be DONE, otherwise idx increments and next state SHALL be ISSUE.
REQ-029 Divide by zero: in ISSUE, an entry with op=DIV and b=0 SHALL NOT assert op_valid; SHALL set res_data to all ones and err_dz to 1 (sticky until next accepted start), and go to RESULT next cycle.
REQ-030 DONE SHALL assert seq_done for one cycle and then return to IDLE.
REQ-031 Minimum latency per entry, with op_ready and res_in_valid both already high: 3 cycles (ISSUE, WAIT, RESULT).

Reset
REQ-032 rst=1 SHALL force IDLE from any state, including mid-sequence, and SHALL zero idx, op_valid, op_a, op_b, op_sel, res_valid, res_data, res_idx, busy, seq_done and err_dz.
REQ-033 Program memory SHALL NOT be cleared by reset.

Structure
REQ-034 Op encodings, the state enum and the program-word field widths SHALL reside in a shared package, arith_pkg.
REQ-035 Program storage SHALL be a sub-module, prog_mem (single write port, asynchronous read).

Verification
REQ-036 Load {ADD,3,5}; count=1; start; ready tied 1; res_in=0x08 -> op_a=3, op_b=5, op_sel=00; res_valid pulse with res_data=0x08, res_idx=0; then seq_done.
REQ-037 Entries {MUL,15,15} and {DIV,9,2}; op_ready held 0 for 4 cycles -> op_valid and operands stay stable; results 0xE1 and 0x14 are delivered in order with res_idx 0 then 1.
REQ-038 Entry {DIV,7,0} -> op_valid never asserted; res_data=0xFF; err_dz=1; seq_done follows.
REQ-039 Assert rst while in WAIT -> all outputs 0 next cycle; a new start re-runs the program with the old program words intact.
REQ-040 start with count=0, start while busy, and load_en while busy -> no state change and program unchanged; count=12 runs 8 entries.
